// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: state encoding, port indices and default widths for the RAM arbiter.
// Shared by mem_arbiter and arb_pick.
package mem_arb_pkg;

   localparam int DEF_ADDR_W = 9;
   localparam int DEF_DATA_W = 32;

   localparam logic P_DATA  = 1'b0;
   localparam logic P_FETCH = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RDATA = 2'd2
   } state_t;

   function automatic logic [1:0] port_onehot(input logic port);
      return port ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// arb_pick: combinational winner select between the data and fetch ports.
// ARB_RR_EN defined: round-robin tie-break on last_gnt; undefined: data port always wins.
module arb_pick
   import mem_arb_pkg::*;
(
   input  logic [1:0] i_req,
   input  logic       i_last_gnt,
   output logic [1:0] o_pick
);

`ifdef ARB_RR_EN
   always_comb begin
      o_pick = i_req;
      // On a tie the port that did not win last time goes next.
      if (i_req == 2'b11) o_pick = port_onehot(~i_last_gnt);
   end
`else
   logic w_unused;
   assign w_unused = i_last_gnt;

   always_comb begin
      o_pick = 2'b00;
      if (i_req[P_DATA])       o_pick = port_onehot(P_DATA);
      else if (i_req[P_FETCH]) o_pick = port_onehot(P_FETCH);
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises data (port 0) and fetch (port 1) accesses onto one single-port RAM
// with a 1-cycle registered read. Define ARB_RR_EN for round-robin ties; default is fixed priority.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              clr_n,
   input  logic [1:0]        req,
   input  logic [1:0]        we,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic [1:0]        gnt,
   output logic [1:0]        rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_we,
   output logic              ram_re,
   input  logic [DATA_W-1:0] ram_rdata
);

   state_t            r_state;
   state_t            w_next_state;
   logic              r_owner;
   logic              r_we_op;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [1:0]        w_pick;
   logic              w_win;
   logic              w_last_gnt;
   logic              w_grant;

`ifdef ARB_RR_EN
   logic r_last_gnt;

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n)       r_last_gnt <= P_FETCH;
      else if (w_grant) r_last_gnt <= w_win;
   end

   assign w_last_gnt = r_last_gnt;
`else
   assign w_last_gnt = P_FETCH;
`endif

   arb_pick u_arb_pick (
      .i_req      (req),
      .i_last_gnt (w_last_gnt),
      .o_pick     (w_pick)
   );

   assign w_win   = w_pick[1];
   assign w_grant = (r_state == IDLE) && (req != 2'b00);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) r_state <= IDLE;
      else        r_state <= w_next_state;
   end

   // Command is captured only on a grant and held through ISSUE for the RAM.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_owner <= P_DATA;
         r_we_op <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else if (w_grant) begin
         r_owner <= w_win;
         r_we_op <= we[w_win];
         r_addr  <= w_win ? addr1 : addr0;
         r_wdata <= w_win ? wdata1 : wdata0;
      end
   end

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_grant) w_next_state = ISSUE;
         ISSUE:   w_next_state = r_we_op ? IDLE : RDATA;
         RDATA:   w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Strobes come straight from state and the latched command, so reset drops them at once.
   always_comb begin
      gnt    = 2'b00;
      rvalid = 2'b00;
      ram_we = 1'b0;
      ram_re = 1'b0;
      case (r_state)
         ISSUE: begin
            gnt    = port_onehot(r_owner);
            ram_we = r_we_op;
            ram_re = ~r_we_op;
         end
         RDATA:   rvalid = port_onehot(r_owner);
         default: ;
      endcase
   end

   assign busy      = (r_state != IDLE);
   assign ram_addr  = r_addr;
   assign ram_wdata = r_wdata;
   assign rdata     = ram_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a cycle-level
// reference model of the arbitration rules and a reference copy of RAM contents.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int AW = 9;
   localparam int DW = 32;

   logic          clk   = 1'b0;
   logic          clr_n = 1'b0;
   logic [1:0]    req;
   logic [1:0]    we;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic [1:0]    gnt, rvalid;
   logic [DW-1:0] rdata;
   logic          busy;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic          ram_we, ram_re;
   logic [DW-1:0] ram_rdata;

   int errors = 0;
   int checks = 0;
   int m_last;                 // model: port granted most recently (1 after reset)
   logic [DW-1:0] ram_mem [512];
   logic [DW-1:0] ref_mem [512];

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk       (clk),
      .clr_n     (clr_n),
      .req       (req),
      .we        (we),
      .addr0     (addr0),
      .addr1     (addr1),
      .wdata0    (wdata0),
      .wdata1    (wdata1),
      .gnt       (gnt),
      .rvalid    (rvalid),
      .rdata     (rdata),
      .busy      (busy),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_we    (ram_we),
      .ram_re    (ram_re),
      .ram_rdata (ram_rdata)
   );

   function automatic logic [DW-1:0] init_word(input int i);
      return 32'h02000054 ^ (32'(i) * 32'h9E3779B1);
   endfunction

   function automatic logic [1:0] oh(input int p);
      return (p == 0) ? 2'b01 : 2'b10;
   endfunction

   // Winner when the given ports are requesting in IDLE.
   function automatic int model_pick(input bit p0, input bit p1);
      if (p0 && p1) begin
`ifdef ARB_RR_EN
         return 1 - m_last;
`else
         return 0;
`endif
      end
      return p0 ? 0 : 1;
   endfunction

   // Single-port RAM with 1-cycle registered read.
   initial begin
      for (int i = 0; i < 512; i++) ram_mem[i] = init_word(i);
      ram_rdata = '0;
      forever begin
         @(posedge clk);
         if (ram_we) ram_mem[ram_addr] <= ram_wdata;
         if (ram_re) ram_rdata <= ram_mem[ram_addr];
      end
   end

   task automatic apply_reset();
      @(negedge clk);
      req   = 2'b00;
      clr_n = 1'b0;
      @(negedge clk);
      clr_n  = 1'b1;
      m_last = 1;
   endtask

   // One access from an idle arbiter; checks latency, strobes, rvalid and read data.
   task automatic do_access(input int port, input logic w, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input string name);
      int waited;
      logic [1:0] exp_oh;
      waited = 0;
      exp_oh = oh(port);
      req[port] = 1'b1;
      we[port]  = w;
      if (port == 0) begin addr0 = a; wdata0 = d; end
      else           begin addr1 = a; wdata1 = d; end
      do begin
         @(negedge clk);
         waited++;
      end while (gnt == 2'b00 && waited < 10);
      checks++;
      if (gnt !== exp_oh) begin errors++; $display("FAIL %s gnt: got %b expected %b", name, gnt, exp_oh); end
      checks++;
      if (waited != 1) begin errors++; $display("FAIL %s grant latency: got %0d expected 1", name, waited); end
      checks++;
      if ({ram_we, ram_re} !== {w, ~w}) begin
         errors++; $display("FAIL %s strobes we/re: got %b%b expected %b%b", name, ram_we, ram_re, w, ~w);
      end
      checks++;
      if (ram_addr !== a) begin errors++; $display("FAIL %s ram_addr: got %h expected %h", name, ram_addr, a); end
      if (w) begin
         checks++;
         if (ram_wdata !== d) begin errors++; $display("FAIL %s ram_wdata: got %h expected %h", name, ram_wdata, d); end
         ref_mem[a] = d;
      end
      m_last    = port;
      req[port] = 1'b0;
      @(negedge clk);
      if (w) begin
         checks++;
         if (rvalid !== 2'b00 || busy !== 1'b0 || ram_we !== 1'b0) begin
            errors++; $display("FAIL %s after write rvalid/busy/we: got %b/%b/%b expected 00/0/0", name, rvalid, busy, ram_we);
         end
      end else begin
         checks++;
         if (rvalid !== exp_oh) begin errors++; $display("FAIL %s rvalid: got %b expected %b", name, rvalid, exp_oh); end
         checks++;
         if (rdata !== ref_mem[a]) begin errors++; $display("FAIL %s rdata: got %h expected %h", name, rdata, ref_mem[a]); end
         checks++;
         if (ram_re !== 1'b0) begin errors++; $display("FAIL %s ram_re in RDATA: got %b expected 0", name, ram_re); end
         @(negedge clk);
         checks++;
         if (busy !== 1'b0) begin errors++; $display("FAIL %s busy after read: got %b expected 0", name, busy); end
      end
   endtask

   task automatic test_reset();
      clr_n = 1'b0;
      req   = 2'b11;
      we    = 2'b00;
      addr0 = 9'h011;
      addr1 = 9'h022;
      wdata0 = '0;
      wdata1 = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({gnt, rvalid, busy, ram_we, ram_re} !== 7'b0) begin
         errors++; $display("FAIL reset strobes gnt/rvalid/busy/we/re: got %b/%b/%b/%b/%b expected zeros",
                            gnt, rvalid, busy, ram_we, ram_re);
      end
      checks++;
      if (ram_addr !== '0 || ram_wdata !== '0) begin
         errors++; $display("FAIL reset ram_addr/ram_wdata: got %h/%h expected 0/0", ram_addr, ram_wdata);
      end
      clr_n  = 1'b1;
      m_last = 1;
      @(negedge clk);
      checks++;
      if (gnt !== 2'b01) begin errors++; $display("FAIL first grant after reset: got %b expected 01", gnt); end
      checks++;
      if (ram_re !== 1'b1 || ram_addr !== 9'h011) begin
         errors++; $display("FAIL first grant re/addr: got %b/%h expected 1/011", ram_re, ram_addr);
      end
      m_last = 0;
      req = 2'b00;
      @(negedge clk);
      checks++;
      if (rvalid !== 2'b01 || rdata !== ref_mem[9'h011]) begin
         errors++; $display("FAIL first read rvalid/rdata: got %b/%h expected 01/%h", rvalid, rdata, ref_mem[9'h011]);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL busy after first read: got %b expected 0", busy); end
   endtask

   task automatic test_fetch_read();
      checks++;
      if (ref_mem[0] !== 32'h02000054) begin
         errors++; $display("FAIL fetch preload: got %h expected 02000054", ref_mem[0]);
      end
      do_access(1, 1'b0, 9'h000, '0, "fetch read 0x00");
   endtask

   task automatic test_write_read();
      do_access(0, 1'b1, 9'h052, 32'h0000002F, "data write 0x52");
      do_access(0, 1'b0, 9'h052, '0, "data read 0x52");
      checks++;
      if (ref_mem[9'h052] !== 32'h0000002F) begin
         errors++; $display("FAIL write model 0x52: got %h expected 0000002f", ref_mem[9'h052]);
      end
   endtask

   task automatic test_tie();
      apply_reset();
      req   = 2'b11;
      we    = 2'b00;
      addr0 = 9'($urandom_range(0, 511));
      addr1 = 9'($urandom_range(0, 511));
      for (int g = 0; g < 4; g++) begin
         int waited;
         int exp_p;
         logic [DW-1:0] exp_d;
         waited = 0;
         exp_p  = model_pick(1'b1, 1'b1);
         do begin
            @(negedge clk);
            waited++;
         end while (gnt == 2'b00 && waited < 10);
         checks++;
         if (gnt !== oh(exp_p)) begin errors++; $display("FAIL tie grant %0d: got %b expected %b", g, gnt, oh(exp_p)); end
         m_last = exp_p;
         if (g == 3) req = 2'b00;
         exp_d = (exp_p == 0) ? ref_mem[addr0] : ref_mem[addr1];
         @(negedge clk);
         checks++;
         if (rvalid !== oh(exp_p) || rdata !== exp_d) begin
            errors++; $display("FAIL tie read %0d rvalid/rdata: got %b/%h expected %b/%h", g, rvalid, rdata, oh(exp_p), exp_d);
         end
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL busy after tie: got %b expected 0", busy); end
   endtask

   task automatic test_reset_mid();
      req[1] = 1'b1;
      we[1]  = 1'b0;
      addr1  = 9'h0A5;
      @(negedge clk);
      checks++;
      if (gnt !== 2'b10 || ram_re !== 1'b1) begin
         errors++; $display("FAIL mid-reset setup gnt/re: got %b/%b expected 10/1", gnt, ram_re);
      end
      req   = 2'b00;
      clr_n = 1'b0;
      #1;
      checks++;
      if ({gnt, ram_we, ram_re, busy} !== 5'b0) begin
         errors++; $display("FAIL mid-reset strobes gnt/we/re/busy: got %b/%b/%b/%b expected zeros", gnt, ram_we, ram_re, busy);
      end
      @(negedge clk);
      clr_n  = 1'b1;
      m_last = 1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if (rvalid !== 2'b00 || busy !== 1'b0) begin
            errors++; $display("FAIL after mid-reset cycle %0d rvalid/busy: got %b/%b expected 00/0", c, rvalid, busy);
         end
      end
      do_access(0, 1'b0, 9'($urandom_range(0, 511)), '0, "read after mid-reset");
   endtask

   task automatic test_random(input int cycles);
      bit            pend [2];
      logic          pw   [2];
      logic [AW-1:0] pa   [2];
      logic [DW-1:0] pd   [2];
      int            phase;
      int            owner;
      logic          o_we;
      logic [AW-1:0] o_addr;
      logic [1:0]    exp_gnt, exp_rv;
      logic [DW-1:0] exp_rd;
      phase = 0; owner = 0; o_we = 1'b0; o_addr = '0;
      exp_gnt = 2'b00; exp_rv = 2'b00; exp_rd = '0;
      pend[0] = 1'b0; pend[1] = 1'b0;
      req = 2'b00;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         checks++;
         if (gnt !== exp_gnt) begin errors++; $display("FAIL rand gnt cycle %0d: got %b expected %b", c, gnt, exp_gnt); end
         checks++;
         if (rvalid !== exp_rv) begin errors++; $display("FAIL rand rvalid cycle %0d: got %b expected %b", c, rvalid, exp_rv); end
         if (exp_rv != 2'b00) begin
            checks++;
            if (rdata !== exp_rd) begin errors++; $display("FAIL rand rdata cycle %0d: got %h expected %h", c, rdata, exp_rd); end
         end
         checks++;
         if ((ram_we & ram_re) !== 1'b0) begin errors++; $display("FAIL rand strobe overlap cycle %0d: we=%b re=%b", c, ram_we, ram_re); end
         checks++;
         if (busy !== (phase != 0)) begin errors++; $display("FAIL rand busy cycle %0d: got %b expected %b", c, busy, phase != 0); end
         if (gnt != 2'b00) begin
            checks++;
            if ($countones(gnt) != 1 || !pend[int'(gnt[1])]) begin
               errors++; $display("FAIL rand grant without one matching req cycle %0d: gnt %b pending %b%b", c, gnt, pend[1], pend[0]);
            end
         end
         if (exp_gnt != 2'b00) begin
            checks++;
            if ({ram_we, ram_re} !== {o_we, ~o_we} || ram_addr !== o_addr) begin
               errors++; $display("FAIL rand command cycle %0d: got we/re/addr %b%b/%h expected %b%b/%h",
                                  c, ram_we, ram_re, ram_addr, o_we, ~o_we, o_addr);
            end
         end
         // Requester drops req once its grant is visible.
         if (phase == 1) begin
            pend[owner] = 1'b0;
            req[owner]  = 1'b0;
         end
         for (int p = 0; p < 2; p++) begin
            if (!pend[p] && !(phase == 1 && owner == p) && $urandom_range(0, 1) == 1) begin
               pend[p] = 1'b1;
               pw[p]   = 1'($urandom_range(0, 1));
               pa[p]   = 9'($urandom_range(0, 511));
               pd[p]   = $urandom;
               req[p]  = 1'b1;
               we[p]   = pw[p];
               if (p == 0) begin addr0 = pa[p]; wdata0 = pd[p]; end
               else        begin addr1 = pa[p]; wdata1 = pd[p]; end
            end
         end
         exp_gnt = 2'b00;
         exp_rv  = 2'b00;
         case (phase)
            0: if (pend[0] || pend[1]) begin
                  owner  = model_pick(pend[0], pend[1]);
                  m_last = owner;
                  o_we   = pw[owner];
                  o_addr = pa[owner];
                  if (o_we) ref_mem[o_addr] = pd[owner];
                  exp_gnt = oh(owner);
                  phase   = 1;
               end
            1: if (o_we) phase = 0;
               else begin
                  phase  = 2;
                  exp_rv = oh(owner);
                  exp_rd = ref_mem[o_addr];
               end
            default: phase = 0;
         endcase
      end
      req = 2'b00;
      repeat (4) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL busy after random traffic: got %b expected 0", busy); end
   endtask

   initial begin
      for (int i = 0; i < 512; i++) ref_mem[i] = init_word(i);
      req = 2'b00; we = 2'b00;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      m_last = 1;
      test_reset();
      test_fetch_read();
      test_write_read();
      test_tie();
      test_reset_mid();
      test_random(600);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached before the summary");
      $fatal(1, "watchdog");
   end

endmodule
